// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_PIPE = 2'd1,
      ARB_AUX  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_PIPE = 2'd1,
      RD_AUX  = 2'd2
   } rd_owner_t;

   localparam int DMEM_RD_LATENCY = 1;
   localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              pipe_req;
   logic              pipe_wr_en;
   logic [ADDR_W-1:0] pipe_addr;
   logic [DATA_W-1:0] pipe_wr_data;
   logic              pipe_stall;
   logic              pipe_rd_valid;
   logic [DATA_W-1:0] pipe_rd_data;

   logic              aux_req;
   logic              aux_wr_en;
   logic [ADDR_W-1:0] aux_addr;
   logic [DATA_W-1:0] aux_wr_data;
   logic              aux_gnt;
   logic              aux_rd_valid;
   logic [DATA_W-1:0] aux_rd_data;

   logic              mem_en;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data;

   modport slave (
      input  pipe_req, pipe_wr_en, pipe_addr, pipe_wr_data,
      output pipe_stall, pipe_rd_valid, pipe_rd_data,
      input  aux_req, aux_wr_en, aux_addr, aux_wr_data,
      output aux_gnt, aux_rd_valid, aux_rd_data,
      output mem_en, mem_wr_en, mem_addr, mem_wr_data,
      input  mem_rd_data
   );

   modport master (
      output pipe_req, pipe_wr_en, pipe_addr, pipe_wr_data,
      input  pipe_stall, pipe_rd_valid, pipe_rd_data,
      output aux_req, aux_wr_en, aux_addr, aux_wr_data,
      input  aux_gnt, aux_rd_valid, aux_rd_data,
      input  mem_en, mem_wr_en, mem_addr, mem_wr_data,
      output mem_rd_data
   );

endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the aux requester has been denied;
// raises force_aux once the limit is reached while aux is still requesting.
module dmem_arb_starve_ctr
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic aux_req,
   input  logic aux_gnt,
   output logic force_aux
);

   localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

   logic [WAIT_CNT_W-1:0] wait_cnt_r;
   logic [WAIT_CNT_W-1:0] wait_cnt_nxt_s;

   // Next count: grow while denied, clear on grant or when aux withdraws
   always_comb begin
      wait_cnt_nxt_s = {WAIT_CNT_W{1'b0}};
      if (aux_req && !aux_gnt) begin
         if (wait_cnt_r == MAX_CNT) begin
            wait_cnt_nxt_s = wait_cnt_r;
         end else begin
            wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         wait_cnt_nxt_s = {WAIT_CNT_W{1'b0}};
      end
   end

   // Counter register
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         wait_cnt_r <= {WAIT_CNT_W{1'b0}};
      end else begin
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   assign force_aux = Reset_n && aux_req && (wait_cnt_r == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the pipeline MEM stage and the aux port.
// Build option DMEM_ARB_RR_EN: round-robin on contention instead of priority + starvation counter.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int AUX_MAX_WAIT = 8
) (
   input  logic          Clk,
   input  logic          Reset_n,
   dmem_arbiter_if.slave bus
);

   arb_state_t        state_r;
   arb_state_t        state_nxt_s;
   rd_owner_t         rd_owner_r;
   rd_owner_t         rd_owner_nxt_s;

   logic              gnt_pipe_s;
   logic              gnt_aux_s;
   logic              mem_en_s;
   logic              mem_wr_en_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_wr_data_s;
   logic              pipe_rd_valid_s;
   logic              aux_rd_valid_s;

`ifndef DMEM_ARB_RR_EN
   logic              force_aux_s;

   dmem_arb_starve_ctr #(
      .MAX_WAIT (AUX_MAX_WAIT)
   ) u_starve_ctr (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .aux_req   (bus.aux_req),
      .aux_gnt   (gnt_aux_s),
      .force_aux (force_aux_s)
   );
`endif

   // Same-cycle grant decision; nothing is granted while in reset
   always_comb begin
      gnt_pipe_s = 1'b0;
      gnt_aux_s  = 1'b0;
      if (!Reset_n) begin
         gnt_pipe_s = 1'b0;
         gnt_aux_s  = 1'b0;
      end else begin
`ifdef DMEM_ARB_RR_EN
         if (bus.pipe_req && bus.aux_req) begin
            if (state_r == ARB_PIPE) begin
               gnt_aux_s = 1'b1;
            end else begin
               gnt_pipe_s = 1'b1;
            end
         end else if (bus.pipe_req) begin
            gnt_pipe_s = 1'b1;
         end else if (bus.aux_req) begin
            gnt_aux_s = 1'b1;
         end else begin
            gnt_pipe_s = 1'b0;
         end
`else
         if (force_aux_s) begin
            gnt_aux_s = 1'b1;
         end else if (bus.pipe_req) begin
            gnt_pipe_s = 1'b1;
         end else if (bus.aux_req) begin
            gnt_aux_s = 1'b1;
         end else begin
            gnt_pipe_s = 1'b0;
         end
`endif
      end
   end

   // RAM port mux driven by the granted requester
   always_comb begin
      mem_en_s      = 1'b0;
      mem_wr_en_s   = 1'b0;
      mem_addr_s    = {ADDR_W{1'b0}};
      mem_wr_data_s = {DATA_W{1'b0}};
      if (gnt_pipe_s) begin
         mem_en_s      = 1'b1;
         mem_wr_en_s   = bus.pipe_wr_en;
         mem_addr_s    = bus.pipe_addr;
         mem_wr_data_s = bus.pipe_wr_data;
      end else if (gnt_aux_s) begin
         mem_en_s      = 1'b1;
         mem_wr_en_s   = bus.aux_wr_en;
         mem_addr_s    = bus.aux_addr;
         mem_wr_data_s = bus.aux_wr_data;
      end else begin
         mem_en_s      = 1'b0;
      end
   end

   // Last-grant owner and read-return owner for the next cycle
   always_comb begin
      state_nxt_s    = state_r;
      rd_owner_nxt_s = RD_NONE;
      case (state_r)
         ARB_IDLE, ARB_PIPE, ARB_AUX: begin
            if (gnt_pipe_s) begin
               state_nxt_s = ARB_PIPE;
            end else if (gnt_aux_s) begin
               state_nxt_s = ARB_AUX;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = ARB_IDLE;
         end
      endcase
      if (gnt_pipe_s && !bus.pipe_wr_en) begin
         rd_owner_nxt_s = RD_PIPE;
      end else if (gnt_aux_s && !bus.aux_wr_en) begin
         rd_owner_nxt_s = RD_AUX;
      end else begin
         rd_owner_nxt_s = RD_NONE;
      end
   end

   // State and read-owner registers
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_r    <= ARB_IDLE;
         rd_owner_r <= RD_NONE;
      end else begin
         state_r    <= state_nxt_s;
         rd_owner_r <= rd_owner_nxt_s;
      end
   end

   // Reset also masks a return already in flight
   assign pipe_rd_valid_s   = Reset_n && (rd_owner_r == RD_PIPE);
   assign aux_rd_valid_s    = Reset_n && (rd_owner_r == RD_AUX);

   assign bus.pipe_rd_valid = pipe_rd_valid_s;
   assign bus.pipe_rd_data  = pipe_rd_valid_s ? bus.mem_rd_data : {DATA_W{1'b0}};
   assign bus.aux_rd_valid  = aux_rd_valid_s;
   assign bus.aux_rd_data   = aux_rd_valid_s ? bus.mem_rd_data : {DATA_W{1'b0}};

   assign bus.pipe_stall    = Reset_n && bus.pipe_req && !gnt_pipe_s;
   assign bus.aux_gnt       = gnt_aux_s;
   assign bus.mem_en        = mem_en_s;
   assign bus.mem_wr_en     = mem_wr_en_s;
   assign bus.mem_addr      = mem_addr_s;
   assign bus.mem_wr_data   = mem_wr_data_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Vector-table bench for dmem_arbiter with a RAM model and a read-return scoreboard.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      logic        p_req;  logic p_wr; logic [31:0] p_addr; logic [31:0] p_wd;
      logic        a_req;  logic a_wr; logic [31:0] a_addr; logic [31:0] a_wd;
      logic        e_stall; logic e_gnt; logic e_en; logic e_wr;
      logic [31:0] e_addr; logic [31:0] e_wd;
   } vec_t;

   typedef struct {
      rd_owner_t   owner;
      logic [31:0] data;
      int          due;
   } ret_t;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AUX_MAX_WAIT(8)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   logic [31:0] ram     [0:255];
   logic [31:0] ref_mem [0:255];
   vec_t        vecs[$];
   ret_t        sb[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;

   // Synchronous single-port RAM model
   always @(posedge Clk) begin
      if (bus.mem_en) begin
         if (bus.mem_wr_en) ram[bus.mem_addr[9:2]] <= bus.mem_wr_data;
         else               bus.mem_rd_data <= ram[bus.mem_addr[9:2]];
      end
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic vec_t mk(input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                               input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                               input logic es, input logic eg, input logic ee, input logic ew,
                               input logic [31:0] ea, input logic [31:0] ed);
      vec_t v;
      v.p_req = pr; v.p_wr = pw; v.p_addr = pa; v.p_wd = pd;
      v.a_req = ar; v.a_wr = aw; v.a_addr = aa; v.a_wd = ad;
      v.e_stall = es; v.e_gnt = eg; v.e_en = ee; v.e_wr = ew; v.e_addr = ea; v.e_wd = ed;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.pipe_req = v.p_req; bus.pipe_wr_en = v.p_wr; bus.pipe_addr = v.p_addr; bus.pipe_wr_data = v.p_wd;
      bus.aux_req  = v.a_req; bus.aux_wr_en  = v.a_wr; bus.aux_addr  = v.a_addr; bus.aux_wr_data  = v.a_wd;
   endtask

   task automatic drive_idle();
      drive(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
   endtask

   // Compare read returns against the scoreboard entry due this cycle
   task automatic check_returns(input string tag);
      ret_t        r;
      logic        exp_p;
      logic        exp_a;
      logic [31:0] exp_d;
      exp_p = 1'b0; exp_a = 1'b0; exp_d = 32'h0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         r = sb.pop_front();
         exp_p = (r.owner == RD_PIPE);
         exp_a = (r.owner == RD_AUX);
         exp_d = r.data;
      end
      chk1({tag, " pipe_rd_valid"}, bus.pipe_rd_valid, exp_p);
      chk1({tag, " aux_rd_valid"}, bus.aux_rd_valid, exp_a);
      if (exp_p) chk32({tag, " pipe_rd_data"}, bus.pipe_rd_data, exp_d);
      if (exp_a) chk32({tag, " aux_rd_data"}, bus.aux_rd_data, exp_d);
   endtask

   // Called just after a rising edge; returns just after the next one
   task automatic apply(input vec_t v, input string tag);
      ret_t r;
      drive(v);
      @(negedge Clk);
      check_returns(tag);
      chk1({tag, " pipe_stall"}, bus.pipe_stall, v.e_stall);
      chk1({tag, " aux_gnt"}, bus.aux_gnt, v.e_gnt);
      chk1({tag, " mem_en"}, bus.mem_en, v.e_en);
      if (v.e_en) begin
         chk1({tag, " mem_wr_en"}, bus.mem_wr_en, v.e_wr);
         chk32({tag, " mem_addr"}, bus.mem_addr, v.e_addr);
         if (v.e_wr) chk32({tag, " mem_wr_data"}, bus.mem_wr_data, v.e_wd);
      end
      if (v.e_en && !v.e_wr) begin
         r.owner = v.e_gnt ? RD_AUX : RD_PIPE;
         r.data  = ref_mem[v.e_addr[9:2]];
         r.due   = cyc + DMEM_RD_LATENCY;
         sb.push_back(r);
      end
      if (v.e_en && v.e_wr) ref_mem[v.e_addr[9:2]] = v.e_wd;
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   initial begin
      logic aux_win;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
         ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      end
      ram[4]     = 32'hDEAD_BEEF;
      ref_mem[4] = 32'hDEAD_BEEF;
      bus.mem_rd_data = 32'h0;

      // Reset with both requesters active: combinational outputs must stay low
      drive(mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk1("rst mem_en", bus.mem_en, 1'b0);
      chk1("rst aux_gnt", bus.aux_gnt, 1'b0);
      chk1("rst pipe_stall", bus.pipe_stall, 1'b0);
      chk1("rst pipe_rd_valid", bus.pipe_rd_valid, 1'b0);
      chk1("rst aux_rd_valid", bus.aux_rd_valid, 1'b0);
      @(posedge Clk);
      #1;
      drive_idle();
      Reset_n = 1'b1;

      //                p_req p_wr p_addr     p_wd          a_req a_wr a_addr     a_wd          stall gnt  en   wr   e_addr     e_wd
      vecs.push_back(mk(1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h40,   32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h1234_5678));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h40,   32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h40,   32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h44,   32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0));
      vecs.push_back(mk(1'b1, 1'b0, 32'h20,   32'h0,        1'b1, 1'b0, 32'h90,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h90,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 32'h20,   32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5));
      vecs.push_back(mk(1'b1, 1'b0, 32'h20,   32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0));
      // Continuous contention: pipe load vs aux write
      for (int i = 0; i < 19; i++) begin
`ifdef DMEM_ARB_RR_EN
         aux_win = (i % 2 == 0);
`else
         aux_win = (i == 8) || (i == 17);
`endif
         if (aux_win)
            vecs.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h80, 32'h55AA_55AA,
                              1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h55AA_55AA));
         else
            vecs.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h80, 32'h55AA_55AA,
                              1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0));
      end
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h80,   32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0));

      foreach (vecs[k]) apply(vecs[k], $sformatf("v%0d", k));
      chk32("scoreboard drained", 32'(sb.size()), 32'd0);

      // Reset lands the cycle after a pipe load grant
      drive(mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
      @(negedge Clk);
      chk1("midrst grant mem_en", bus.mem_en, 1'b1);
      @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      bus.aux_req = 1'b1;
      @(negedge Clk);
      chk1("midrst pipe_rd_valid", bus.pipe_rd_valid, 1'b0);
      chk32("midrst pipe_rd_data", bus.pipe_rd_data, 32'h0);
      chk1("midrst aux_rd_valid", bus.aux_rd_valid, 1'b0);
      chk1("midrst mem_en", bus.mem_en, 1'b0);
      chk1("midrst pipe_stall", bus.pipe_stall, 1'b0);
      chk1("midrst aux_gnt", bus.aux_gnt, 1'b0);
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      drive(mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
      @(negedge Clk);
      chk1("postrst pipe_rd_valid", bus.pipe_rd_valid, 1'b0);
      chk1("postrst aux_gnt", bus.aux_gnt, 1'b0);
      chk32("postrst mem_addr", bus.mem_addr, 32'h10);
      @(posedge Clk);
      #1;
      drive_idle();
      @(negedge Clk);
      chk1("postrst load valid", bus.pipe_rd_valid, 1'b1);
      chk32("postrst load data", bus.pipe_rd_data, 32'hDEAD_BEEF);
      chk1("postrst aux quiet", bus.aux_rd_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data RAM between two requesters.
- Pipeline MEM stage: primary requester.
- Auxiliary port (program loader / debug): secondary requester.
Fixed priority goes to the pipeline, with a starvation counter that forces an aux grant. The block sits between the MEM stage's memory-control outputs and the RAM. It stalls the pipeline whenever the aux requester owns the RAM.

Parameters:
ADDR_W, 32, address width of both requesters and the RAM.
DATA_W, 32, data width.
AUX_MAX_WAIT, 8, consecutive cycles aux may be denied before a forced grant (1..255).

Ports:
Clk  in  1  clock
Reset_n  in  1  reset
pipe_req  in  1  pipeline access request (load or store) this cycle
pipe_wr_en  in  1  1=store, 0=load
pipe_addr  in  ADDR_W  pipeline address
pipe_wr_data  in  DATA_W  pipeline store data (already masked)
pipe_stall  out  1  pipeline must hold; request not taken this cycle
pipe_rd_valid  out  1  load data valid on pipe_rd_data
pipe_rd_data  out  DATA_W  load return data
aux_req  in  1  aux request; held until aux_gnt
aux_wr_en  in  1  1=write, 0=read
aux_addr  in  ADDR_W  aux address
aux_wr_data  in  DATA_W  aux write data
aux_gnt  out  1  aux request accepted this cycle
aux_rd_valid  out  1  aux read data valid
aux_rd_data  out  DATA_W  aux read return data
mem_en  out  1  RAM port enable
mem_wr_en  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wr_data  out  DATA_W  RAM write data
mem_rd_data  in  DATA_W  RAM read data, valid 1 cycle after a read with mem_en

Behaviour:
- Reset: Reset_n is synchronous, active-low; Clk is the clock. All registered state clears: state=IDLE, wait_cnt=0, rd_owner=NONE, pipe_rd_valid=0, aux_rd_valid=0.
- Combinational outputs (mem_*, aux_gnt, pipe_stall) are 0 while Reset_n=0.
- Grant decision is combinational in the same cycle:
  - force = (wait_cnt == AUX_MAX_WAIT) && aux_req.
  - If force: grant aux; pipe_stall = pipe_req.
  - Else if pipe_req: grant pipe; pipe_stall=0.
  - Else if aux_req: grant aux.
  - Else: no grant, mem_en=0.
- The granted requester's addr/wr_en/wr_data drive mem_*; mem_en=1.
- aux_gnt=1 exactly in the aux-grant cycle.
- wait_cnt:
  - Increments (saturating at AUX_MAX_WAIT) each cycle aux_req=1 and aux is not granted.
  - Clears on aux grant or when aux_req=0.
- Read tracking: on a granted read, rd_owner <= granted requester; else rd_owner <= NONE.
- Read return, next cycle:
  - rd_owner=PIPE: pipe_rd_valid=1 and pipe_rd_data=mem_rd_data.
  - rd_owner=AUX: aux_rd_valid=1 and aux_rd_data=mem_rd_data.
  - Latency is exactly 1 cycle; back-to-back reads are supported every cycle.
- State machine (registered owner of the last grant, used for debug visibility and the RR option):
  - IDLE -> PIPE on pipe grant; IDLE -> AUX on aux grant; IDLE stays on no grant.
  - PIPE/AUX transition identically based on the current cycle's grant.
- Simultaneous pipe_req and aux_req without force: pipe wins, aux waits.
- A write produces no rd_valid.
- Reset mid-read: the pending rd_valid is suppressed, and the return data is dropped.
- aux must hold req/addr/data stable until aux_gnt. Behaviour on deassertion before grant: the counter clears and no access occurs.

Optional Feature:
DMEM_ARB_RR_EN
- Defined: strict round-robin on contention. When both request, the requester not granted last (per state) wins; wait_cnt and force logic are removed.
- Undefined: fixed priority plus starvation counter, as above.

Decomposition:
- Package RV32I_definitions gains:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_PIPE, ARB_AUX} arb_state_t
  - typedef enum logic [1:0] {RD_NONE, RD_PIPE, RD_AUX} rd_owner_t
  - localparam DMEM_RD_LATENCY=1
- One sub-module is natural: dmem_arb_starve_ctr (saturating wait counter with force output), omitted under DMEM_ARB_RR_EN.

Test Plan:
- Pipe-only load, addr 0x10, RAM returns 0xDEADBEEF -> mem_en=1, mem_wr_en=0 cycle N; pipe_rd_valid=1, data 0xDEADBEEF cycle N+1; pipe_stall=0 throughout.
- Aux-only write, addr 0x40, data 0x12345678 -> aux_gnt=1 same cycle, mem_wr_en=1, mem_addr=0x40; no rd_valid next cycle.
- pipe_req and aux_req both held continuously, AUX_MAX_WAIT=8 -> pipe granted 8 cycles; cycle 9 aux_gnt=1, pipe_stall=1; wait_cnt back to 0; pipe resumes cycle 10.
- Alternating pipe read / aux read every cycle -> each rd_valid routed to the correct owner one cycle later; no cross-delivery.
- Reset_n driven low the cycle after a pipe read grant -> pipe_rd_valid stays 0, all outputs 0, state=IDLE.
- With DMEM_ARB_RR_EN, both requesting continuously -> grants alternate pipe, aux, pipe...; pipe_stall=1 on aux cycles.
